// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream packet generator with NetFPGA tuser metadata; NF10_AXIS_PKT_GEN_LFSR_EN selects LFSR payload.
// Latency: first beat is valid one cycle after start is accepted in IDLE.
// Backpressure: the presented beat and payload state hold while tvalid && !tready; packets are never truncated.
module nf10_axis_pkt_gen #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT           = 8'h01,
    parameter logic [7:0]  C_DST_PORT           = 8'h04
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              start,
    input  logic                              stop,
    input  logic [15:0]                       cfg_pkt_count,
    input  logic [15:0]                       cfg_pkt_len,
    input  logic [7:0]                        cfg_ipg,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic                              done,
    output logic [31:0]                       pkts_sent
);
    localparam int          BYTES   = C_M_AXIS_DATA_WIDTH / 8;
    localparam int          LANES   = C_M_AXIS_DATA_WIDTH / 32;
    localparam logic [15:0] BYTES16 = 16'(BYTES);
    localparam logic [15:0] MIN_LEN = 16'd60;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  ipg_q, ipg_d;
    logic [15:0] rem_q, rem_d;     // bytes left in the packet, counting the beat on the bus
    logic [11:0] beat_q, beat_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic [7:0]  gap_q, gap_d;

    logic                           xfer;
    logic                           last_beat;
    logic                           run_complete;
    logic [15:0]                    start_len;
    logic [C_M_AXIS_DATA_WIDTH-1:0] payload;

    assign xfer         = (state_q == ST_SEND) && m_axis_tready;
    assign last_beat    = (rem_q <= BYTES16);
    assign run_complete = (count_q != 16'd0) && ((sent_q + 32'd1) == {16'd0, count_q});
    assign start_len    = (cfg_pkt_len < MIN_LEN) ? MIN_LEN : cfg_pkt_len;

`ifdef NF10_AXIS_PKT_GEN_LFSR_EN
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    logic [31:0] lfsr_q, lfsr_d, lfsr_next;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // lane 0 carries the current state; the register jumps ahead by one step per lane on a transfer
    always_comb begin
        logic [31:0] s;
        s       = lfsr_q;
        payload = '0;
        for (int i = 0; i < LANES; i++) begin
            payload[i*32 +: 32] = s;
            s = lfsr_step(s);
        end
        lfsr_next = s;
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_IDLE && start) begin
            lfsr_d = LFSR_SEED;
        end else if (xfer) begin
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        payload = '0;
        for (int i = 0; i < LANES; i++) begin
            payload[i*32 +: 32] = {seq_q, beat_q, 4'(i)};
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        ipg_d   = ipg_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        seq_d   = seq_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = cfg_pkt_count;
                    len_d   = start_len;
                    ipg_d   = cfg_ipg;
                    rem_d   = start_len;
                    beat_d  = 12'd0;
                    seq_d   = 16'd0;
                    sent_d  = 32'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (last_beat) begin
                        sent_d = sent_q + 32'd1;
                        seq_d  = seq_q + 16'd1;
                        beat_d = 12'd0;
                        rem_d  = len_q;
                        if (run_complete || stop) begin
                            state_d = ST_DONE;
                        end else if (ipg_q != 8'd0) begin
                            gap_d   = ipg_q;
                            state_d = ST_GAP;
                        end
                    end else begin
                        beat_d = beat_q + 12'd1;
                        rem_d  = rem_q - BYTES16;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (gap_q <= 8'd1) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            count_q <= 16'd0;
            len_q   <= 16'd0;
            ipg_q   <= 8'd0;
            rem_q   <= 16'd0;
            beat_q  <= 12'd0;
            seq_q   <= 16'd0;
            sent_q  <= 32'd0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            ipg_q   <= ipg_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
        end
    end

    // outputs are pure functions of held state, so a stalled beat cannot change
    always_comb begin
        m_axis_tvalid = (state_q == ST_SEND);
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        if (m_axis_tvalid) begin
            m_axis_tlast       = last_beat;
            m_axis_tdata       = payload;
            m_axis_tuser[31:0] = {C_DST_PORT, C_SRC_PORT, len_q};
            for (int i = 0; i < BYTES; i++) begin
                m_axis_tstrb[i] = (16'(i) < rem_q);
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign pkts_sent = sent_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Randomized bench for nf10_axis_pkt_gen against a packet-level reference model.
module tb_nf10_axis_pkt_gen;
    localparam int DW    = 256;
    localparam int UW    = 128;
    localparam int BB    = DW / 8;
    localparam int LANES = DW / 32;

    logic          aclk          = 1'b0;
    logic          areset        = 1'b1;
    logic          start         = 1'b0;
    logic          stop          = 1'b0;
    logic [15:0]   cfg_pkt_count = 16'd0;
    logic [15:0]   cfg_pkt_len   = 16'd0;
    logic [7:0]    cfg_ipg       = 8'd0;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic [BB-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [31:0]   pkts_sent;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .C_SRC_PORT          (8'h01),
        .C_DST_PORT          (8'h04)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .start        (start),
        .stop         (stop),
        .cfg_pkt_count(cfg_pkt_count),
        .cfg_pkt_len  (cfg_pkt_len),
        .cfg_ipg      (cfg_ipg),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .pkts_sent    (pkts_sent)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: one packet of L bytes is ceil(L/B) beats
    function automatic logic [DW-1:0] exp_dat(input int seq, input int b);
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = {16'(seq), 12'(b), 4'(i)};
        return d;
    endfunction

    function automatic logic [BB-1:0] exp_strb(input int len, input int b, input int n);
        if (b < n - 1 || (len % BB) == 0) return '1;
        return BB'((64'd1 << (len % BB)) - 64'd1);
    endfunction

    function automatic logic [UW-1:0] exp_user(input int len);
        return {96'd0, 8'h04, 8'h01, 16'(len)};
    endfunction

    // monitor: records accepted beats, checks hold-while-stalled, counts gap and done cycles
    logic [DW-1:0] q_dat[$];
    logic [BB-1:0] q_strb[$];
    logic [UW-1:0] q_user[$];
    logic          q_last[$];
    int            cyc = 0, gap_cycles = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] h_dat;
    logic [BB-1:0] h_strb;
    logic [UW-1:0] h_user;
    logic          h_last;

    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_vld",  256'(m_axis_tvalid), 256'(1));
                chk("hold_dat",  256'(m_axis_tdata),  256'(h_dat));
                chk("hold_strb", 256'(m_axis_tstrb),  256'(h_strb));
                chk("hold_user", 256'(m_axis_tuser),  256'(h_user));
                chk("hold_last", 256'(m_axis_tlast),  256'(h_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                q_dat.push_back(m_axis_tdata);
                q_strb.push_back(m_axis_tstrb);
                q_user.push_back(m_axis_tuser);
                q_last.push_back(m_axis_tlast);
                if (m_axis_tlast) last_cyc = cyc;
            end
            if (busy && !m_axis_tvalid && !done) gap_cycles++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            h_dat   = m_axis_tdata;
            h_strb  = m_axis_tstrb;
            h_user  = m_axis_tuser;
            h_last  = m_axis_tlast;
        end
    end

    task automatic run(input int len, input int cnt, input int ipg, input int pct, input int stop_k);
        int L, n, npk, nb, bad0, t;
        L   = (len < 60) ? 60 : len;
        n   = (L + BB - 1) / BB;
        npk = (cnt == 0) ? stop_k : cnt;
        nb  = npk * n;
        q_dat.delete(); q_strb.delete(); q_user.delete(); q_last.delete();
        gap_cycles = 0; done_cnt = 0; done_cyc = 0; last_cyc = 0;
        @(posedge aclk); #1;
        cfg_pkt_len = 16'(len); cfg_pkt_count = 16'(cnt); cfg_ipg = 8'(ipg); start = 1'b1;
        @(posedge aclk); #1;
        // scramble config and poke start mid-run: both must be ignored
        start = 1'b0;
        cfg_pkt_len = 16'($urandom); cfg_pkt_count = 16'($urandom); cfg_ipg = 8'($urandom);
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            m_axis_tready = ($urandom_range(99) < 32'(pct));
            start = ($urandom_range(15) == 0);
            if (stop_k > 0 && q_last.size() > (stop_k - 1) * n) stop = 1'b1;
            @(posedge aclk); #1;
            t++;
        end
        start = 1'b0;
        stop  = 1'b0;
        m_axis_tready = 1'b1;
        chk("run_done", 256'(done_cnt > 0), 256'(1));
        chk("nbeats", 256'(q_dat.size()), 256'(nb));
        bad0 = bad;
        for (int k = 0; k < q_dat.size() && k < nb && bad == bad0; k++) begin
            chk("tdata", 256'(q_dat[k]),  256'(exp_dat(k / n, k % n)));
            chk("tstrb", 256'(q_strb[k]), 256'(exp_strb(L, k % n, n)));
            chk("tuser", 256'(q_user[k]), 256'(exp_user(L)));
            chk("tlast", 256'(q_last[k]), 256'((k % n) == n - 1));
        end
        @(negedge aclk);
        chk("pkts_sent", 256'(pkts_sent),           256'(npk));
        chk("gap_cyc",   256'(gap_cycles),          256'(ipg * (npk - 1)));
        chk("done_cnt",  256'(done_cnt),            256'(1));
        chk("done_lat",  256'(done_cyc - last_cyc), 256'(1));
        chk("idle_busy", 256'(busy),                256'(0));
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_vld",  256'(m_axis_tvalid), 256'(0));
        chk("rst_last", 256'(m_axis_tlast),  256'(0));
        chk("rst_busy", 256'(busy),          256'(0));
        chk("rst_done", 256'(done),          256'(0));
        chk("rst_dat",  256'(m_axis_tdata),  256'(0));
        chk("rst_strb", 256'(m_axis_tstrb),  256'(0));
        chk("rst_user", 256'(m_axis_tuser),  256'(0));
        chk("rst_sent", 256'(pkts_sent),     256'(0));
        @(posedge aclk); #1 areset = 1'b0;

        run(64, 1, 0, 100, 0);
        run(100, 2, 3, 100, 0);
        run(10, 1, 0, 100, 0);
        run(200, 5, 0, 50, 0);
        run(200, 0, 0, 100, 3);

        // reset in the middle of a free-running packet
        @(posedge aclk); #1;
        cfg_pkt_len = 16'd200; cfg_pkt_count = 16'd0; cfg_ipg = 8'd0; start = 1'b1; m_axis_tready = 1'b1;
        @(posedge aclk); #1 start = 1'b0;
        repeat (9) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("mid_rst_vld",  256'(m_axis_tvalid), 256'(0));
        chk("mid_rst_sent", 256'(pkts_sent),     256'(0));
        chk("mid_rst_busy", 256'(busy),          256'(0));
        run(64, 1, 0, 100, 0);

        for (int r = 0; r < 8; r++) begin
            int cnt, sk, pct;
            cnt = int'($urandom_range(4, 0));
            sk  = (cnt == 0) ? int'($urandom_range(3, 1)) : 0;
            pct = ($urandom_range(1) == 1) ? 100 : int'($urandom_range(90, 30));
            run(int'($urandom_range(300, 1)), cnt, int'($urandom_range(4, 0)), pct, sk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
